// File: rtl/savestate_pkg.sv
// rtl/savestate_pkg.sv - shared types and constants for the savestate sequencer
//
// Purpose: FSM state and transfer-mode enums plus the default header magic.
// Ports:   none (package).

package savestate_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PAUSE,
        ST_HDR,
        ST_SS_RD,
        ST_SS_CAP,
        ST_MEM_WR,
        ST_LD_RD,
        ST_SS_WR,
        ST_FINISH,
        ST_ABORT
    } state_e;

    typedef enum logic {
        MODE_SAVE,
        MODE_LOAD
    } mode_e;

    localparam logic [31:0] SS_MAGIC_DEFAULT = 32'h7A6D_0001;

endpackage

// File: rtl/savestate_mem_port.sv
// rtl/savestate_mem_port.sv - external memory request holder for the savestate sequencer
//
// Purpose: launches a single read or write on the external memory, holds the
//          strobe until mem_ack, and latches read data.
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   clear_i            drop any pending strobe immediately
//   wr_start_i         launch a write of wdata_i to addr_i
//   rd_start_i         launch a read of addr_i
//   addr_i, wdata_i    request address / write data
//   ack_o              completion of the pending request (mem_ack qualified)
//   rdata_o            last word returned by a completed read
//   mem_*              external memory interface

module savestate_mem_port #(
    parameter int MEM_AW = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              wr_start_i,
    input  logic              rd_start_i,
    input  logic [MEM_AW-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ack_o,
    output logic [31:0]       rdata_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ack_i
);

    logic              we_q, we_d;
    logic              re_q, re_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    // An ack with no strobe outstanding is not ours and is ignored.
    assign ack_o = mem_ack_i & (we_q | re_q);

    always_comb begin
        we_d    = we_q;
        re_d    = re_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (re_q && mem_ack_i) begin
            rdata_d = mem_rdata_i;
        end
        // A new launch may coincide with the ack of the previous request
        // (header read followed directly by the first image read), so the
        // launch takes priority over the ack-driven release.
        if (clear_i) begin
            we_d = 1'b0;
            re_d = 1'b0;
        end else if (wr_start_i) begin
            we_d    = 1'b1;
            re_d    = 1'b0;
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end else if (rd_start_i) begin
            we_d   = 1'b0;
            re_d   = 1'b1;
            addr_d = addr_i;
        end else if (ack_o) begin
            we_d = 1'b0;
            re_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            we_q    <= we_d;
            re_q    <= re_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_we_o    = we_q;
    assign mem_re_o    = re_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;

endmodule

// File: rtl/savestate_sequencer.sv
// rtl/savestate_sequencer.sv - cpu_6s46 savestate save/load sequencer
//
// Purpose: on save, pauses the CPU, reads every savestate word over the ss bus
//          and writes them to external memory behind a magic header; on load,
//          checks the header and writes the image back over the ss bus.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   save_req, load_req             single-cycle operation requests
//   busy, done, error              status (done/error are one-cycle pulses)
//   cpu_pause, cpu_paused          CPU halt handshake
//   ss_bus_in/addr/wren/reset/out  CPU savestate bus
//   mem_addr/wdata/we/re/rdata/ack external 32-bit word memory

module savestate_sequencer
    import savestate_pkg::*;
#(
    parameter int          SS_WORDS      = 64,
    parameter int          MEM_BASE      = 0,
    parameter int          MEM_AW        = 16,
    parameter int          PAUSE_TIMEOUT = 1024,
    parameter logic [31:0] SS_MAGIC      = SS_MAGIC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              save_req,
    input  logic              load_req,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_pause,
    input  logic              cpu_paused,
    output logic [31:0]       ss_bus_in,
    output logic [7:0]        ss_bus_addr,
    output logic              ss_bus_wren,
    output logic              ss_bus_reset,
    input  logic [31:0]       ss_bus_out,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int                CNT_W        = $clog2(PAUSE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(PAUSE_TIMEOUT - 1);
    localparam logic [7:0]        LAST_IDX     = 8'(SS_WORDS - 1);
    localparam logic [MEM_AW-1:0] BASE_ADDR    = MEM_AW'(MEM_BASE);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [7:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ss_bus_reset_q;

    logic              wr_start, rd_start, hdr_req, port_clear, port_ack;
    logic [MEM_AW-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       port_rdata;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        wr_start = 1'b0;
        rd_start = 1'b0;
        hdr_req  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Save has priority when both requests arrive together.
                if (save_req) begin
                    state_d = ST_PAUSE;
                    mode_d  = MODE_SAVE;
                    cnt_d   = '0;
                end else if (load_req) begin
                    state_d = ST_PAUSE;
                    mode_d  = MODE_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_PAUSE: begin
                if (cpu_paused) begin
                    state_d = ST_HDR;
                    hdr_req = 1'b1;
                    if (mode_q == MODE_SAVE) begin
                        wr_start = 1'b1;
                    end else begin
                        rd_start = 1'b1;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_ABORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HDR: begin
                if (port_ack) begin
                    idx_d = 8'h00;
                    if (mode_q == MODE_SAVE) begin
                        state_d = ST_SS_RD;
                    end else if (mem_rdata == SS_MAGIC) begin
                        state_d  = ST_LD_RD;
                        rd_start = 1'b1;
                    end else begin
                        state_d = ST_ABORT;
                    end
                end
            end
            ST_SS_RD: begin
                state_d = ST_SS_CAP;
            end
            ST_SS_CAP: begin
                // ss_bus_out now reflects the address presented in SS_RD;
                // it is captured straight into the memory write register.
                state_d  = ST_MEM_WR;
                wr_start = 1'b1;
            end
            ST_MEM_WR: begin
                if (port_ack) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d   = idx_q + 8'h01;
                        state_d = ST_SS_RD;
                    end
                end
            end
            ST_LD_RD: begin
                if (port_ack) begin
                    state_d = ST_SS_WR;
                end
            end
            ST_SS_WR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_FINISH;
                end else begin
                    idx_d    = idx_q + 8'h01;
                    state_d  = ST_LD_RD;
                    rd_start = 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Image words live at MEM_BASE+1+i; the address wraps at 2^MEM_AW.
    always_comb begin
        req_addr  = BASE_ADDR + MEM_AW'(1) + MEM_AW'(idx_d);
        req_wdata = ss_bus_out;
        if (hdr_req) begin
            req_addr  = BASE_ADDR;
            req_wdata = SS_MAGIC;
        end
    end

    assign port_clear = (state_q == ST_ABORT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_SAVE;
            idx_q   <= 8'h00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered copy of reset: high during reset, low the cycle after release.
    always_ff @(posedge clk) begin
        ss_bus_reset_q <= reset;
    end

    assign ss_bus_reset = ss_bus_reset_q;

    always_comb begin
        busy        = 1'b0;
        cpu_pause   = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        ss_bus_addr = 8'h00;
        ss_bus_in   = 32'h0;
        ss_bus_wren = 1'b0;
        unique case (state_q)
            ST_PAUSE, ST_HDR, ST_MEM_WR, ST_LD_RD: begin
                busy      = 1'b1;
                cpu_pause = 1'b1;
            end
            ST_SS_RD, ST_SS_CAP: begin
                busy        = 1'b1;
                cpu_pause   = 1'b1;
                ss_bus_addr = idx_q;
            end
            ST_SS_WR: begin
                busy        = 1'b1;
                cpu_pause   = 1'b1;
                ss_bus_addr = idx_q;
                ss_bus_in   = port_rdata;
                ss_bus_wren = 1'b1;
            end
            ST_FINISH: begin
                done = 1'b1;
            end
            ST_ABORT: begin
                error = 1'b1;
            end
            default: begin
            end
        endcase
    end

    savestate_mem_port #(
        .MEM_AW(MEM_AW)
    ) u_mem_port (
        .clk_i      (clk),
        .reset_i    (reset),
        .clear_i    (port_clear),
        .wr_start_i (wr_start),
        .rd_start_i (rd_start),
        .addr_i     (req_addr),
        .wdata_i    (req_wdata),
        .ack_o      (port_ack),
        .rdata_o    (port_rdata),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_we_o   (mem_we),
        .mem_re_o   (mem_re),
        .mem_rdata_i(mem_rdata),
        .mem_ack_i  (mem_ack)
    );

endmodule

// File: tb/tb_savestate_sequencer.sv
// tb/tb_savestate_sequencer.sv - scoreboard bench for savestate_sequencer

module tb_savestate_sequencer;

    localparam int          SS_WORDS      = 4;
    localparam int          MEM_AW        = 16;
    localparam int          PAUSE_TIMEOUT = 16;
    localparam logic [31:0] MAGIC         = 32'h7A6D_0001;

    localparam int EV_MEMW = 1;
    localparam int EV_SSW  = 2;
    localparam int EV_DONE = 3;
    localparam int EV_ERR  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              save_req = 1'b0;
    logic              load_req = 1'b0;
    logic              busy, done, error, cpu_pause;
    logic              cpu_paused = 1'b0;
    logic [31:0]       ss_bus_in;
    logic [7:0]        ss_bus_addr;
    logic              ss_bus_wren, ss_bus_reset;
    logic [31:0]       ss_bus_out = 32'h0;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we, mem_re;
    logic [31:0]       mem_rdata = 32'h0;
    logic              mem_ack = 1'b0;

    savestate_sequencer #(
        .SS_WORDS     (SS_WORDS),
        .MEM_BASE     (0),
        .MEM_AW       (MEM_AW),
        .PAUSE_TIMEOUT(PAUSE_TIMEOUT),
        .SS_MAGIC     (MAGIC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .save_req    (save_req),
        .load_req    (load_req),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .cpu_pause   (cpu_pause),
        .cpu_paused  (cpu_paused),
        .ss_bus_in   (ss_bus_in),
        .ss_bus_addr (ss_bus_addr),
        .ss_bus_wren (ss_bus_wren),
        .ss_bus_reset(ss_bus_reset),
        .ss_bus_out  (ss_bus_out),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    always #5 clk = ~clk;

    // Models: zero-wait memory, CPU register file, CPU pause acknowledge.
    logic [31:0] mem_arr  [0:15];
    logic [31:0] cpu_regs [0:3];
    int          pause_delay = 3;
    int          pcnt = 0;

    always @(posedge clk) begin
        if ((mem_we || mem_re) && !mem_ack) begin
            mem_ack   <= 1'b1;
            mem_rdata <= mem_arr[mem_addr[3:0]];
        end else begin
            mem_ack <= 1'b0;
        end
        ss_bus_out <= cpu_regs[ss_bus_addr[1:0]];
        if (!cpu_pause) begin
            pcnt       <= 0;
            cpu_paused <= 1'b0;
        end else begin
            pcnt       <= pcnt + 1;
            cpu_paused <= (pcnt + 1 >= pause_delay);
        end
    end

    int busy_tot = 0, pause_tot = 0, strobe_tot = 0, re_tot = 0, wren_tot = 0, done_tot = 0;

    always @(negedge clk) begin
        busy_tot   <= busy_tot + int'(busy);
        pause_tot  <= pause_tot + int'(cpu_pause);
        strobe_tot <= strobe_tot + int'(mem_we | mem_re);
        re_tot     <= re_tot + int'(mem_re);
        wren_tot   <= wren_tot + int'(ss_bus_wren);
        done_tot   <= done_tot + int'(done);
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];

    task automatic push(input int k, input logic [15:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input int k, input logic [15:0] a, input logic [31:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h expected none", k, a, d);
        end else begin
            e = exp_q.pop_front();
            chk("sb_kind", 32'(k), 32'(e.kind));
            chk("sb_addr", {16'h0, a}, {16'h0, e.addr});
            chk("sb_data", d, e.data);
        end
    endtask

    // Monitor: every output transaction the DUT presents is matched in order.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we && mem_ack) sb_pop(EV_MEMW, mem_addr, mem_wdata);
            if (ss_bus_wren)       sb_pop(EV_SSW, {8'h00, ss_bus_addr}, ss_bus_in);
            if (done)              sb_pop(EV_DONE, 16'h0, 32'h0);
            if (error)             sb_pop(EV_ERR, 16'h0, 32'h0);
        end
    end

    task automatic pulse_req(input logic s, input logic l);
        @(negedge clk);
        save_req = s;
        load_req = l;
        @(negedge clk);
        save_req = 1'b0;
        load_req = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int cyc;
        cyc = 0;
        while (!(done || error) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 300) chk({name, "_timeout"}, 32'(cyc), 32'd0);
    endtask

    task automatic push_save(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
        push(EV_MEMW, 16'd0, MAGIC);
        push(EV_MEMW, 16'd1, w0);
        push(EV_MEMW, 16'd2, w1);
        push(EV_MEMW, 16'd3, w2);
        push(EV_MEMW, 16'd4, w3);
        push(EV_DONE, 16'd0, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b0, p0, s0, r0, w0, d0, cyc;
        for (int i = 0; i < 16; i++) mem_arr[i] = 32'h0;
        for (int i = 0; i < 4; i++) cpu_regs[i] = 32'h0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_flags", {24'h0, busy, done, error, cpu_pause, ss_bus_wren, ss_bus_reset, mem_we, mem_re},
            32'h0000_0004);
        chk("rst_ss_addr", {24'h0, ss_bus_addr}, 32'h0);
        chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("ss_bus_reset_release", {31'h0, ss_bus_reset}, 32'h0);

        // 1: save of {A,B,C,D}, cpu_paused 3 cycles after cpu_pause
        cpu_regs[0] = 32'hA; cpu_regs[1] = 32'hB; cpu_regs[2] = 32'hC; cpu_regs[3] = 32'hD;
        pause_delay = 3;
        push_save(32'hA, 32'hB, 32'hC, 32'hD);
        @(negedge clk);
        b0 = busy_tot;
        pulse_req(1'b1, 1'b0);
        wait_end("t1");
        chk("t1_cpu_pause_at_done", {31'h0, cpu_pause}, 32'h0);
        chk("t1_busy_at_done", {31'h0, busy}, 32'h0);
        @(negedge clk);
        chk("t1_busy_cycles", 32'(busy_tot - b0), 32'd22);
        chk("t1_done_single", {31'h0, done}, 32'h0);
        chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // 2: load of {magic,1,2,3,4}
        mem_arr[0] = MAGIC; mem_arr[1] = 32'd1; mem_arr[2] = 32'd2; mem_arr[3] = 32'd3; mem_arr[4] = 32'd4;
        for (int i = 0; i < 4; i++) push(EV_SSW, 16'(i), 32'(i + 1));
        push(EV_DONE, 16'd0, 32'h0);
        w0 = wren_tot;
        pulse_req(1'b0, 1'b1);
        wait_end("t2");
        @(negedge clk);
        chk("t2_wren_count", 32'(wren_tot - w0), 32'd4);
        chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // 3: load with bad magic
        mem_arr[0] = 32'hDEAD_BEEF;
        push(EV_ERR, 16'd0, 32'h0);
        w0 = wren_tot;
        pulse_req(1'b0, 1'b1);
        wait_end("t3");
        chk("t3_cpu_pause_at_error", {31'h0, cpu_pause}, 32'h0);
        r0 = re_tot;
        repeat (10) @(negedge clk);
        chk("t3_mem_re_after_error", 32'(re_tot - r0), 32'd0);
        chk("t3_wren_count", 32'(wren_tot - w0), 32'd0);
        chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // 4: simultaneous requests, then load_req while busy
        cpu_regs[0] = 32'h11; cpu_regs[1] = 32'h22; cpu_regs[2] = 32'h33; cpu_regs[3] = 32'h44;
        mem_arr[0] = MAGIC;
        push_save(32'h11, 32'h22, 32'h33, 32'h44);
        d0 = done_tot;
        w0 = wren_tot;
        pulse_req(1'b1, 1'b1);
        repeat (5) @(negedge clk);
        chk("t4_busy_mid", {31'h0, busy}, 32'h1);
        pulse_req(1'b0, 1'b1);
        wait_end("t4");
        repeat (40) @(negedge clk);
        chk("t4_done_count", 32'(done_tot - d0), 32'd1);
        chk("t4_wren_count", 32'(wren_tot - w0), 32'd0);
        chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // 5: pause timeout
        pause_delay = 1000;
        push(EV_ERR, 16'd0, 32'h0);
        @(negedge clk);
        p0 = pause_tot;
        s0 = strobe_tot;
        b0 = busy_tot;
        pulse_req(1'b1, 1'b0);
        wait_end("t5");
        @(negedge clk);
        chk("t5_pause_cycles", 32'(pause_tot - p0), 32'd16);
        chk("t5_busy_cycles", 32'(busy_tot - b0), 32'd16);
        chk("t5_mem_strobes", 32'(strobe_tot - s0), 32'd0);
        chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // 6: reset while word 2 write is pending, then a fresh save
        pause_delay = 3;
        cpu_regs[0] = 32'h5; cpu_regs[1] = 32'h6; cpu_regs[2] = 32'h7; cpu_regs[3] = 32'h8;
        push(EV_MEMW, 16'd0, MAGIC);
        push(EV_MEMW, 16'd1, 32'h5);
        push(EV_MEMW, 16'd2, 32'h6);
        pulse_req(1'b1, 1'b0);
        cyc = 0;
        while (!(mem_we && mem_addr == 16'd3) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 100) chk("t6_word2_timeout", 32'(cyc), 32'd0);
        chk("t6_word2_data", mem_wdata, 32'h7);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_strobes_after_reset",
            {25'h0, cpu_pause, mem_we, mem_re, ss_bus_wren, busy, done, error}, 32'h0);
        chk("t6_ss_bus_reset_high", {31'h0, ss_bus_reset}, 32'h1);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_ss_bus_reset_low", {31'h0, ss_bus_reset}, 32'h0);
        chk("t6_queue_after_reset", 32'(exp_q.size()), 32'd0);
        push_save(32'h5, 32'h6, 32'h7, 32'h8);
        pulse_req(1'b1, 1'b0);
        wait_end("t6");
        @(negedge clk);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
